// File: rtl/modulo_unit.sv
// Sequential remainder unit: restoring shift-subtract over a 2*BIT+1 bit dividend, one bit per clock.
// Optional macro MODULO_DIV0_EN: a zero divisor finishes after one cycle with M = all ones.
module modulo_unit #(
    parameter int BIT = 8
) (
    input  logic           clk,
    input  logic           start,
    output logic           busy,
    input  logic [BIT-1:0] C,
    input  logic [BIT:0]   Hreg,
    input  logic [BIT-1:0] Lreg,
    output logic [BIT-1:0] M,
    input  logic           rst
);

    localparam int DW = 2 * BIT + 1;
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            start_prev_q, start_prev_d;
    logic [BIT-1:0]  m_q, m_d;
    logic [BIT-1:0]  rem_q, rem_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BIT-1:0]  c_q, c_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [BIT:0]    rem_trial;
    logic [BIT-1:0]  rem_next;
    logic            launch;

    // The stored remainder is always below the divisor, so only the
    // shifted trial value needs the extra top bit.
    always_comb begin
        rem_trial = {rem_q, div_q[DW-1]};
        rem_next  = rem_trial[BIT-1:0];
        if (rem_trial >= {1'b0, c_q}) begin
            rem_next = BIT'(rem_trial - {1'b0, c_q});
        end
    end

    assign launch = (state_q == IDLE) && start && !start_prev_q;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        start_prev_d = start;
        m_d          = m_q;
        rem_d        = rem_q;
        div_d        = div_q;
        c_d          = c_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    c_d     = C;
                    div_d   = {Hreg, Lreg};
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
`ifdef MODULO_DIV0_EN
                if (c_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    m_d     = '1;
                    rem_d   = '0;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_next;
                    div_d = {div_q[DW-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        m_d     = rem_next;
                    end
                end
`else
                rem_d = rem_next;
                div_d = {div_q[DW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    m_d     = rem_next;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b0;
            m_q          <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            c_q          <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            start_prev_q <= start_prev_d;
            m_q          <= m_d;
            rem_q        <= rem_d;
            div_q        <= div_d;
            c_q          <= c_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign M    = m_q;

endmodule

// File: tb/tb_modulo_unit.sv
// Directed-vector bench for modulo_unit: remainders, latency, start handling and reset abort.
module tb_modulo_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic [7:0] C;
    logic [8:0] Hreg;
    logic [7:0] Lreg;
    logic [7:0] M;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_prev = 8'h00;

    modulo_unit #(.BIT(8)) dut (
        .clk  (clk),
        .start(start),
        .busy (busy),
        .C    (C),
        .Hreg (Hreg),
        .Lreg (Lreg),
        .M    (M),
        .rst  (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation, scramble the operands, then count busy cycles.
    task automatic run_op(input string tag, input logic [8:0] h, input logic [7:0] l,
                          input logic [7:0] c, input logic [7:0] exp_m, input int exp_cyc);
        int cyc;
        @(negedge clk);
        C = c; Hreg = h; Lreg = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0; C = 8'h5A; Hreg = 9'h133; Lreg = 8'hC3;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 1) check({tag, "_hold"}, 32'(M), 32'(exp_prev));
            @(negedge clk);
        end
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_m"}, 32'(M), 32'(exp_m));
        exp_prev = exp_m;
        $display("op %s: dividend=%05h C=%02h M=%02h busy_cycles=%0d", tag, {h, l}, c, M, cyc);
    endtask

    initial begin
        int falls;
        int high;
        logic prev_busy;

        rst = 1'b1; start = 1'b0; C = '0; Hreg = '0; Lreg = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_m", 32'(M), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: busy=%0b M=%02h", busy, M);

        run_op("one_mod_one", 9'h000, 8'h01, 8'h01, 8'h00, 17);
        run_op("x1111_aa",    9'h011, 8'h11, 8'hAA, 8'h77, 17);
        run_op("xaaaa_ff",    9'h0AA, 8'hAA, 8'hFF, 8'h55, 17);
        run_op("xffff_ff",    9'h0FF, 8'hFF, 8'hFF, 8'h00, 17);
        run_op("x1ffff_fe",   9'h1FF, 8'hFF, 8'hFE, 8'h07, 17);
        run_op("x1ffff_ff",   9'h1FF, 8'hFF, 8'hFF, 8'h01, 17);
        run_op("max_c1",      9'h1FF, 8'hFF, 8'h01, 8'h00, 17);
        run_op("x12345_07",   9'h123, 8'h45, 8'h07, 8'h01, 17);
        run_op("small_div",   9'h000, 8'h05, 8'h09, 8'h05, 17);
`ifdef MODULO_DIV0_EN
        run_op("div0",        9'h012, 8'hAB, 8'h00, 8'hFF, 1);
`else
        run_op("div0",        9'h012, 8'hAB, 8'h00, 8'hAB, 17);
`endif

        // start held high well past completion must produce a single operation
        @(negedge clk);
        C = 8'hFF; Hreg = 9'h0AA; Lreg = 8'hAA; start = 1'b1;
        falls = 0; high = 0; prev_busy = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (i == 29) start = 1'b0;
            if (busy === 1'b1) high++;
            if (prev_busy === 1'b1 && busy === 1'b0) falls++;
            prev_busy = busy;
        end
        check("hold_falls", 32'(falls), 32'd1);
        check("hold_high", 32'(high), 32'd17);
        check("hold_m", 32'(M), 32'h55);
        exp_prev = 8'h55;
        $display("hold: busy_falls=%0d busy_cycles=%0d M=%02h", falls, high, M);

        // reset in the middle of an operation aborts it
        @(negedge clk);
        C = 8'hFE; Hreg = 9'h1FF; Lreg = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_m", 32'(M), 32'h0);
        rst = 1'b0;
        exp_prev = 8'h00;
        repeat (2) @(negedge clk);
        check("abort_idle", 32'(busy), 32'h0);
        $display("abort: busy=%0b M=%02h", busy, M);
        run_op("after_abort", 9'h011, 8'h11, 8'hAA, 8'h77, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
